// File: rtl/rf_wb_trace_buffer.sv
// rf_wb_trace_buffer: circular trace of RF writebacks with PC trigger.
// Optional per-entry cycle timestamp via TRACE_TIMESTAMP_EN.
module rf_wb_trace_buffer #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int DEPTH  = 64,
    parameter int PTR_W  = 6
`ifdef TRACE_TIMESTAMP_EN
    ,
    parameter int TS_W   = 16
`endif
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              CAP_WE,
    input  logic [AWIDTH-1:0] CAP_WA,
    input  logic [DWIDTH-1:0] CAP_WD,
    input  logic [DWIDTH-1:0] CAP_PC,
    input  logic              ARM,
    input  logic              TRIG_EN,
    input  logic [DWIDTH-1:0] TRIG_PC,
    input  logic [PTR_W:0]    POST_CNT,
    input  logic              RD_REQ,
    output logic              RD_VALID,
    output logic [AWIDTH-1:0] RD_WA,
    output logic [DWIDTH-1:0] RD_WD,
    output logic [DWIDTH-1:0] RD_PC,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]   RD_TS,
`endif
    output logic [1:0]        STATE,
    output logic [PTR_W:0]    COUNT,
    output logic              TRIGGERED
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        POST  = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [PTR_W-1:0] P1   = PTR_W'(1);
    localparam logic [PTR_W:0]   C1   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   FULL = {1'b1, {PTR_W{1'b0}}};

    state_t            state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    remain;
    logic              triggered;

    logic [AWIDTH-1:0] mem_wa [DEPTH];
    logic [DWIDTH-1:0] mem_wd [DEPTH];
    logic [DWIDTH-1:0] mem_pc [DEPTH];

    logic cap;
    logic hit;
    logic full;
    logic pop;
    logic rd_valid;

    assign cap      = CAP_WE && (CAP_WA != '0)
                   && (state == ARMED || state == POST);
    assign hit      = TRIG_EN && (CAP_PC == TRIG_PC);
    assign full     = (count == FULL);
    assign rd_valid = (state == DONE) && (count != '0);
    assign pop      = rd_valid && RD_REQ;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            remain    <= '0;
            triggered <= 1'b0;
        end else if (ARM) begin
            state     <= ARMED;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            triggered <= 1'b0;
        end else begin
            // A full buffer drops its oldest entry to make room
            if (cap) begin
                wr_ptr <= wr_ptr + P1;
                if (full)
                    rd_ptr <= rd_ptr + P1;
                else
                    count <= count + C1;
            end else if (pop) begin
                rd_ptr <= rd_ptr + P1;
                count  <= count - C1;
            end

            unique case (1'b1)
                cap && state == ARMED && hit: begin
                    triggered <= 1'b1;
                    if (POST_CNT == '0) begin
                        state <= DONE;
                    end else begin
                        remain <= POST_CNT;
                        state  <= POST;
                    end
                end
                cap && state == POST: begin
                    remain <= remain - C1;
                    if (remain == C1)
                        state <= DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (cap && !ARM) begin
            mem_wa[wr_ptr] <= CAP_WA;
            mem_wd[wr_ptr] <= CAP_WD;
            mem_pc[wr_ptr] <= CAP_PC;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    localparam logic [TS_W-1:0] T1 = TS_W'(1);

    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] mem_ts [DEPTH];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            ts_q <= '0;
        else if (ARM)
            ts_q <= '0;
        else
            ts_q <= ts_q + T1;
    end

    // Stamp holds the number of edges since the ARM edge
    always_ff @(posedge CLK) begin
        if (cap && !ARM)
            mem_ts[wr_ptr] <= ts_q + T1;
    end

    assign RD_TS = rd_valid ? mem_ts[rd_ptr] : '0;
`endif

    assign RD_VALID  = rd_valid;
    assign RD_WA     = rd_valid ? mem_wa[rd_ptr] : '0;
    assign RD_WD     = rd_valid ? mem_wd[rd_ptr] : '0;
    assign RD_PC     = rd_valid ? mem_pc[rd_ptr] : '0;
    assign STATE     = state;
    assign COUNT     = count;
    assign TRIGGERED = triggered;

endmodule
